mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Multicycle signed multiply/divide unit for the MIPS-subset CPU. It consumes the A and B operand registers and produces the values written into the HI and LO registers for mult/div instructions. It raises the divide-by-zero flag that the control unit receives as ErroDiv. It also gives the control unit a start/busy/done handshake, so the FSM can stall in its mult/div state until the result is ready.

Parameters:
WIDTH, 32, operand width; product and dividend paths are internally 2*WIDTH.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only while idle
op  input  1  0 = mult (signed), 1 = div (signed)
a  input  WIDTH  multiplicand / dividend (A register)
b  input  WIDTH  multiplier / divisor (B register)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when hi/lo (or div_zero) are final
div_zero  output  1  one-cycle pulse, concurrent with done, on div with b == 0
hi  output  WIDTH  mult: product[2W-1:W]; div: remainder
lo  output  WIDTH  mult: product[W-1:0]; div: quotient

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: hi = lo = 0, busy = done = div_zero = 0, FSM = IDLE. Reset mid-operation aborts the operation; no done is issued.
- FSM states: IDLE, MULT, DIV, FINISH.
- IDLE:
  - On the edge where start = 1, latch a, b and op, then set busy = 1.
  - op = 0: go to MULT.
  - op = 1, b != 0: go to DIV.
  - op = 1, b == 0: go to FINISH with an error flag.
- MULT: radix-2 Booth algorithm, one step per cycle, exactly WIDTH cycles, then FINISH.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle, exactly WIDTH cycles, then FINISH.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Results are negated per sign at the transition into FINISH.
- FINISH: lasts one cycle.
  - hi/lo are updated on the edge entering FINISH and are visible during it.
  - done = 1 for this cycle; busy drops to 0 on the same edge that raises done.
  - Next state is IDLE.
- Latency, with start sampled at edge k:
  - mult and normal div: done is high in the cycle following edge k + WIDTH + 1.
  - divide-by-zero: done and div_zero are high in the cycle following edge k + 1, and hi/lo keep their previous values.
- Result holding: hi/lo hold their value until the next successful completion. They are never cleared except by reset.
- start while busy (MULT, DIV or FINISH) is ignored. Operand inputs may change freely after the start edge.
- Corner cases:
  - div of -2^W-1 by -1: lo = 0x80000000, hi = 0; no error is raised.
  - Any magnitude of -2^W-1 is handled as unsigned 2^W-1.
  - mult of -2^W-1 by -2^W-1 gives the exact 64-bit result.
- Overflow: no overflow flag is produced for mult/div.

Test Plan:
- Reset, then mult a = 7, b = 0xFFFFFFFD (-3), start at edge k → done pulse after edge k+33; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for cycles k..k+32.
- mult a = b = 0x80000000 → hi = 0x40000000, lo = 0x00000000; then div a = 0xFFFFFFF9 (-7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Preload hi/lo via a mult (hi = 0, lo = 6), then div a = 5, b = 0 → done and div_zero both high the cycle after edge k+1; hi = 0, lo = 6 unchanged; no further pulse.
- div a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_zero = 0.
- Second start asserted at cycle k+5 of a running mult, with different operands → ignored; the result matches the first operands; the next start after done is accepted.
- reset asserted at cycle k+10 of a div → busy = done = 0, hi = lo = 0 on the next cycle; a subsequent mult 3 × 4 → lo = 12, hi = 0.

Source files
------------

// File: rtl/mult_div_if.sv
// Handshake and operand/result bundle between the control unit and the
// multiply/divide unit.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Requester side: issues operations, observes status and results.
    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    // Unit side: accepts operations, produces status and results.
    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit feeding the HI/LO registers.
// Multiply uses radix-2 Booth recoding, one step per cycle; divide uses
// restoring division on operand magnitudes, one quotient bit per cycle,
// with signs applied on the way into FINISH.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    mult_div_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t           state_reg;
    logic [WIDTH:0]   acc_reg;     // Booth accumulator / partial remainder
    logic [WIDTH-1:0] q_reg;       // multiplier shifter / dividend-quotient shifter
    logic             qm1_reg;     // Booth q[-1] bit
    logic [WIDTH-1:0] m_reg;       // multiplicand / divisor magnitude
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             err_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             div_zero_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    // Two's-complement negate of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1).
    assign a_mag = bus.a[WIDTH-1] ? negate(bus.a) : bus.a;
    assign b_mag = bus.b[WIDTH-1] ? negate(bus.b) : bus.b;

    // Booth step: add/subtract the sign-extended multiplicand per {q0, q-1}.
    // The extra accumulator bit keeps -2^(WIDTH-1) from overflowing.
    always_comb begin
        booth_sum = acc_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   booth_sum = acc_reg + {m_reg[WIDTH-1], m_reg};
            2'b10:   booth_sum = acc_reg - {m_reg[WIDTH-1], m_reg};
            default: booth_sum = acc_reg;
        endcase
    end

    // Restoring step: shift in the next dividend bit and trial-subtract.
    // The partial remainder stays below 2*divisor, so bit WIDTH is the sign.
    assign rem_shift = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, m_reg};

    // Sign correction applied when the division completes.
    assign quo_final = neg_q_reg ? negate(q_reg) : q_reg;
    assign rem_final = neg_r_reg ? negate(acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];

    // Control FSM and datapath registers with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            q_reg        <= '0;
            qm1_reg      <= 1'b0;
            m_reg        <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            err_reg      <= 1'b0;
            count_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        busy_reg  <= 1'b1;
                        count_reg <= '0;
                        acc_reg   <= '0;
                        qm1_reg   <= 1'b0;
                        neg_q_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_r_reg <= bus.a[WIDTH-1];
                        err_reg   <= 1'b0;
                        if (!bus.op) begin
                            q_reg     <= bus.a;
                            m_reg     <= bus.b;
                            state_reg <= MULT;
                        end else if (bus.b == '0) begin
                            err_reg   <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            q_reg     <= a_mag;
                            m_reg     <= b_mag;
                            state_reg <= DIV;
                        end
                    end
                end
                MULT: begin
                    if (count_reg == CW'(WIDTH)) begin
                        hi_reg    <= acc_reg[WIDTH-1:0];
                        lo_reg    <= q_reg;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        acc_reg   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        q_reg     <= {booth_sum[0], q_reg[WIDTH-1:1]};
                        qm1_reg   <= q_reg[0];
                        count_reg <= count_reg + CW'(1);
                    end
                end
                DIV: begin
                    if (count_reg == CW'(WIDTH)) begin
                        hi_reg    <= rem_final;
                        lo_reg    <= quo_final;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        acc_reg   <= trial[WIDTH] ? rem_shift : trial;
                        q_reg     <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
                        count_reg <= count_reg + CW'(1);
                    end
                end
                FINISH: begin
                    // A zero divisor arrives here one cycle early with the
                    // error pending; it raises done/div_zero on the next edge
                    // and leaves hi/lo untouched.
                    if (err_reg) begin
                        err_reg      <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        div_zero_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
endmodule
